// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// FSM state encoding and the per-digit add-3 correction constants.
package bin2bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the next left shift, so the shifted digit carries cleanly into the next one.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGN_EN to treat bin_in as two's complement (magnitude + sign).
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | adjusting and shifting one bit per clock, BIN_W cycles
// DONE  | one-cycle done pulse; a new start may be accepted here
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  sign
);

    localparam int BCD_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic               accept;
    logic               last_shift;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   bin_sr;
    logic [BIN_W-1:0]   load_val;
    logic [BCD_W-1:0]   bcd_acc;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic               ovf_acc;
    logic               ovf_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (bcd_acc[4*i +: 4]),
            .adj   (bcd_adj[4*i +: 4])
        );
    end

`ifdef BIN2BCD_SIGN_EN
    // BIN_W bits suffice: |-2^(BIN_W-1)| is still representable as unsigned.
    assign load_val = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
`else
    assign load_val = bin_in;
`endif

    // A set bit leaving the top digit means the value needs more digits.
    assign bcd_next   = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
    assign ovf_next   = ovf_acc | bcd_adj[BCD_W-1];
    assign last_shift = (state_q == S_SHIFT) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            bin_sr   <= '0;
            bcd_acc  <= '0;
            ovf_acc  <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            cnt_q   <= CNT_W'(BIN_W);
            bin_sr  <= load_val;
            bcd_acc <= '0;
            ovf_acc <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            cnt_q   <= cnt_q - CNT_W'(1);
            bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
            bcd_acc <= bcd_next;
            ovf_acc <= ovf_next;
            if (last_shift) begin
                bcd_out  <= bcd_next;
                overflow <= ovf_next;
            end
        end
    end

`ifdef BIN2BCD_SIGN_EN
    logic sign_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_acc <= 1'b0;
            sign     <= 1'b0;
        end else if (accept) begin
            sign_acc <= bin_in[BIN_W-1];
        end else if (last_shift) begin
            sign <= sign_acc;
        end
    end
`else
    assign sign = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_seq;

    localparam int BIN_W = 8;

    typedef struct {
        int          due;
        logic [11:0] bcd_a;
        logic        ovf_a;
        logic [7:0]  bcd_b;
        logic        ovf_b;
        logic        sgn;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;

    logic        busy_a, done_a, ovf_a, sign_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b, sign_b;
    logic [7:0]  bcd_b;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   rem = 0;
    exp_t qa[$];
    exp_t qb[$];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a), .sign(sign_a)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b), .sign(sign_b)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] to_bcd(input longint v, input int d);
        logic [63:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r = r | (64'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [BIN_W-1:0] b, input int due);
        exp_t   e;
        longint v;
`ifdef BIN2BCD_SIGN_EN
        e.sgn = b[BIN_W-1];
        v = b[BIN_W-1] ? (longint'(1) << BIN_W) - longint'(b) : longint'(b);
`else
        e.sgn = 1'b0;
        v = longint'(b);
`endif
        e.due   = due;
        e.bcd_a = 12'(to_bcd(v, 3));
        e.ovf_a = (v >= 1000);
        e.bcd_b = 8'(to_bcd(v, 2));
        e.ovf_b = (v >= 100);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a converter is free whenever it is not counting out its BIN_W shifts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            rem <= 0;
            qa.delete();
            qb.delete();
        end else if (rem == 0) begin
            if (start) begin
                rem <= BIN_W;
                qa.push_back(mk(bin_in, cyc + 1 + BIN_W));
                qb.push_back(mk(bin_in, cyc + 1 + BIN_W));
            end
        end else begin
            rem <= rem - 1;
        end
    end

    always @(negedge clk) begin
        exp_t ea;
        exp_t eb;
        if (rst_n) begin
            chk("busy_a", busy_a, rem > 0);
            chk("busy_b", busy_b, rem > 0);
            if (done_a) begin
                if (qa.size() == 0) chk("spurious_done_a", done_a, 1'b0);
                else begin
                    ea = qa.pop_front();
                    chk("latency_a", cyc, ea.due);
                    chk("bcd_a", bcd_a, ea.bcd_a);
                    chk("ovf_a", ovf_a, ea.ovf_a);
                    chk("sign_a", sign_a, ea.sgn);
                end
            end
            if (done_b) begin
                if (qb.size() == 0) chk("spurious_done_b", done_b, 1'b0);
                else begin
                    eb = qb.pop_front();
                    chk("latency_b", cyc, eb.due);
                    chk("bcd_b", bcd_b, eb.bcd_b);
                    chk("ovf_b", ovf_b, eb.ovf_b);
                    chk("sign_b", sign_b, eb.sgn);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
        chk({tag, "_done"}, {done_a, done_b}, 2'b00);
        chk({tag, "_bcd_a"}, bcd_a, 12'h000);
        chk({tag, "_bcd_b"}, bcd_b, 8'h00);
        chk({tag, "_ovf"}, {ovf_a, ovf_b}, 2'b00);
        chk({tag, "_sign"}, {sign_a, sign_b}, 2'b00);
    endtask

    // Called at #1 after a rising edge; leaves at #1 after the accepting edge.
    task automatic go(input logic [BIN_W-1:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < BIN_W + 4; i++) begin
            @(posedge clk); #1;
            if (done_a) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", BIN_W + 4, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        go(8'd0);     wait_done();
        go(8'd255);   wait_done();
        go(8'd99);    wait_done();
        go(8'd100);   wait_done();
        go(8'd255);   wait_done();
        idle(1);

        // start held high with bin_in changing every cycle
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bin_in = BIN_W'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        idle(BIN_W + 2);

        // abort mid-conversion with async reset
        go(8'd200);
        idle(3);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        go(8'd37);    wait_done();

        go(8'h80);    wait_done();
        go(8'hFF);    wait_done();
        go(8'd127);   wait_done();
        idle(1);

        for (int n = 0; n < 40; n++) begin
            go(BIN_W'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end

        idle(BIN_W + 3);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
